// File: rtl/axi_lite_rr_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rr_master_arbiter_if
// Brief    : AXI4-Lite bus bundle between the arbiter (master) and a slave.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_rr_master_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rr_master_arbiter
// Brief    : Round-robin arbiter sharing one AXI4-Lite master port among
//            NUM_REQ command/response requesters, one transaction in flight.
//            Define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_rr_master_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  wire                            ACLK,
    input  wire                            ARESET,
    input  wire  [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  wire  [NUM_REQ-1:0]             req_write,
    input  wire  [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  wire  [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  wire  [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    axi_lite_rr_master_arbiter_if.master   m_axi
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

    state_t                  r_state;
    logic [GW-1:0]           r_grant;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [SW-1:0]           r_wstrb;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;

    logic [GW-1:0]           w_base;
    logic [GW-1:0]           w_grant;
    logic                    w_grant_vld;

    // Requester index k positions above base, wrapping at NUM_REQ.
    function automatic logic [GW-1:0] f_rr_index(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [GW-1:0] r_rr_ptr;
    assign w_base = r_rr_ptr;
`endif

    // Scan downward so the candidate closest to the base is the last writer.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[f_rr_index(w_base, k)]) begin
                w_grant     = f_rr_index(w_base, k);
                w_grant_vld = 1'b1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE && w_grant_vld && !ARESET)
                     ? (NUM_REQ'(1) << w_grant) : '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_grant <= w_grant;
`ifndef AXI_ARB_FIXED_PRIO_EN
                        r_rr_ptr <= f_rr_index(w_grant, 1);
`endif
                        if (req_write[w_grant]) begin
                            r_awaddr  <= req_addr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
                            r_wdata   <= req_wdata[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
                            r_wstrb   <= req_wstrb[int'(w_grant)*SW +: SW];
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_ADDR;
                        end else begin
                            r_araddr  <= req_addr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_ADDR: begin
                    // AW and W complete independently; B is awaited once both are done.
                    if (m_axi.AWREADY) r_awvalid <= 1'b0;
                    if (m_axi.WREADY)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || m_axi.AWREADY) && (!r_wvalid || m_axi.WREADY)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi.BVALID) begin
                        r_rsp_resp  <= m_axi.BRESP;
                        r_rsp_valid <= NUM_REQ'(1) << r_grant;
                        r_bready    <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi.RVALID) begin
                        r_rsp_rdata <= m_axi.RDATA;
                        r_rsp_resp  <= m_axi.RRESP;
                        r_rsp_valid <= NUM_REQ'(1) << r_grant;
                        r_rready    <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axi.AWVALID = r_awvalid;
    assign m_axi.AWADDR  = r_awaddr;
    assign m_axi.WVALID  = r_wvalid;
    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = r_wstrb;
    assign m_axi.BREADY  = r_bready;
    assign m_axi.ARVALID = r_arvalid;
    assign m_axi.ARADDR  = r_araddr;
    assign m_axi.RREADY  = r_rready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_rr_master_arbiter
// Brief    : Scoreboard bench with a configurable-latency AXI4-Lite slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_rr_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              ACLK;
    logic              ARESET;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_wstrb;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;

    axi_lite_rr_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_rr_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axi     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    logic [31:0] s_mem [16] = '{default: '0};
    logic        s_aw_got, s_w_got;
    logic [7:0]  s_aw_a;
    logic [31:0] s_w_d;
    logic [3:0]  s_w_s;
    int          s_aw_cnt, s_w_cnt, s_b_cnt;

    assign bus.AWREADY = bus.AWVALID && !s_aw_got && (s_aw_cnt >= cfg_aw_wait);
    assign bus.WREADY  = bus.WVALID  && !s_w_got  && (s_w_cnt  >= cfg_w_wait);
    assign bus.ARREADY = bus.ARVALID && !bus.RVALID;

    wire        s_aw_now = s_aw_got || (bus.AWVALID && bus.AWREADY);
    wire        s_w_now  = s_w_got  || (bus.WVALID  && bus.WREADY);
    wire [7:0]  s_ea     = s_aw_got ? s_aw_a : bus.AWADDR;
    wire [31:0] s_ed     = s_w_got  ? s_w_d  : bus.WDATA;
    wire [3:0]  s_es     = s_w_got  ? s_w_s  : bus.WSTRB;

    always @(posedge ACLK) begin
        if (ARESET) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0;
            bus.BVALID <= 1'b0; bus.BRESP <= 2'b00;
            bus.RVALID <= 1'b0; bus.RRESP <= 2'b00; bus.RDATA <= '0;
        end else begin
            if (bus.AWVALID && !s_aw_got) begin
                if (bus.AWREADY) begin s_aw_got <= 1'b1; s_aw_a <= bus.AWADDR; s_aw_cnt <= 0; end
                else s_aw_cnt <= s_aw_cnt + 1;
            end
            if (bus.WVALID && !s_w_got) begin
                if (bus.WREADY) begin s_w_got <= 1'b1; s_w_d <= bus.WDATA; s_w_s <= bus.WSTRB; s_w_cnt <= 0; end
                else s_w_cnt <= s_w_cnt + 1;
            end
            if (bus.BVALID && bus.BREADY) bus.BVALID <= 1'b0;
            if (!bus.BVALID && s_aw_now && s_w_now) begin
                if (s_b_cnt >= cfg_b_wait) begin
                    for (int b = 0; b < 4; b++)
                        if (s_es[b]) s_mem[s_ea[5:2]][b*8 +: 8] <= s_ed[b*8 +: 8];
                    bus.BVALID <= 1'b1;
                    bus.BRESP  <= cfg_bresp;
                    s_aw_got <= 1'b0; s_w_got <= 1'b0; s_b_cnt <= 0;
                end else s_b_cnt <= s_b_cnt + 1;
            end
            if (bus.RVALID && bus.RREADY) bus.RVALID <= 1'b0;
            if (bus.ARVALID && bus.ARREADY) begin
                bus.RVALID <= 1'b1;
                bus.RRESP  <= cfg_rresp;
                bus.RDATA  <= (cfg_rresp != 2'b00) ? 32'h0 : s_mem[bus.ARADDR[5:2]];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          req;
        bit          is_rd;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb_q[$];
    int          grant_log[$];
    logic [31:0] ref_mem [16] = '{default: '0};
    exp_t        acc_e;
    exp_t        rsp_e;
    logic [7:0]  acc_a;

    always @(posedge ACLK) begin
        if (ARESET) sb_q.delete();
        else begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_a       = req_addr[i*AW +: AW];
                    acc_e.req   = i;
                    acc_e.is_rd = !req_write[i];
                    if (req_write[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (req_wstrb[i*SW + b]) ref_mem[acc_a[5:2]][b*8 +: 8] = req_wdata[i*DW + b*8 +: 8];
                        acc_e.rdata = '0;
                        acc_e.resp  = cfg_bresp;
                    end else begin
                        acc_e.rdata = (cfg_rresp != 2'b00) ? 32'h0 : ref_mem[acc_a[5:2]];
                        acc_e.resp  = cfg_rresp;
                    end
                    sb_q.push_back(acc_e);
                    grant_log.push_back(i);
                end
            end
        end
    end

    always @(negedge ACLK) begin
        if (!ARESET && rsp_valid != '0) begin
            if (sb_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                rsp_e = sb_q.pop_front();
                chk("rsp_target", rsp_valid, NR'(1) << rsp_e.req);
                chk("rsp_resp", rsp_resp, rsp_e.resp);
                if (rsp_e.is_rd) chk("rsp_rdata", rsp_rdata, rsp_e.rdata);
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic issue(input int i, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n;
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
        req_valid[i] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[i] && n < 300) begin
            @(negedge ACLK); #1; n++;
        end
        if (!req_ready[i]) begin
            chk("issue_timeout_ready", req_ready[i], 1);
            req_valid[i] = 1'b0;
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.BREADY || bus.RREADY || bus.AWVALID || bus.WVALID || bus.ARVALID)
               && n < 200) begin
            @(negedge ACLK); n++;
        end
        chk("drain_queue", sb_q.size(), 0);
        @(negedge ACLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int awv_n, wv_n, bready_n, rsp_n, wd_bad, rr_bad;

    initial begin
        ARESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge ACLK);
        chk("reset_axi_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY}, 0);
        chk("reset_addr_data", {bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB}, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata_resp", {rsp_rdata, rsp_resp}, 0);
        chk("reset_req_ready", req_ready, 0);
        ARESET = 1'b0;

        // Single write, cycle-accurate against a zero-wait slave.
        req_write[0] = 1'b1; req_addr[0 +: AW] = 8'h08;
        req_wdata[0 +: DW] = 32'hDEADBEEF; req_wstrb[0 +: SW] = 4'hF; req_valid[0] = 1'b1;
        #1;
        chk("wr_c0_req_ready", req_ready, 2'b01);
        @(posedge ACLK); @(negedge ACLK);
        req_valid[0] = 1'b0;
        #1;
        chk("wr_c1_aw_w_valid", {bus.AWVALID, bus.WVALID}, 2'b11);
        chk("wr_c1_awaddr", bus.AWADDR, 8'h08);
        chk("wr_c1_wdata_wstrb", {bus.WDATA, bus.WSTRB}, {32'hDEADBEEF, 4'hF});
        chk("wr_c1_req_ready", req_ready, 0);
        @(negedge ACLK);
        chk("wr_c2_bready_bvalid", {bus.BREADY, bus.BVALID}, 2'b11);
        @(negedge ACLK);
        chk("wr_c3_rsp_valid", rsp_valid, 2'b01);
        chk("wr_c3_rsp_resp", rsp_resp, 2'b00);
        drain();
        issue(1, 1'b0, 8'h08, 32'h0, 4'h0);
        drain();
        chk("rd_after_wr_rdata", rsp_rdata, 32'hDEADBEEF);

        // Partial-strobe write then read back.
        issue(0, 1'b1, 8'h10, 32'h11223344, 4'h5);
        drain();
        issue(1, 1'b0, 8'h10, 32'h0, 4'h0);
        drain();

        // Both requesters continuously reading.
        grant_log.delete();
        fork
            begin for (int j = 0; j < 4; j++) issue(0, 1'b0, 8'h08, 32'h0, 4'h0); end
            begin for (int j = 0; j < 4; j++) issue(1, 1'b0, 8'h10, 32'h0, 4'h0); end
        join
        drain();
        chk("rr_grant_count", grant_log.size(), 8);
`ifdef AXI_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) chk("fixed_grant_order", grant_log.size() > k ? grant_log[k] : 99, 0);
`else
        for (int k = 0; k < 4; k++) chk("rr_grant_order", grant_log.size() > k ? grant_log[k] : 99, k % 2);
`endif

        // Split AW/W: WREADY stalled three cycles past AWREADY.
        cfg_w_wait = 3;
        issue(0, 1'b1, 8'h14, 32'hA5A55A5A, 4'hF);
        awv_n = 0; wv_n = 0; bready_n = 0; rsp_n = 0; wd_bad = 0;
        for (int c = 1; c <= 12; c++) begin
            awv_n    += bus.AWVALID;
            wv_n     += bus.WVALID;
            bready_n += bus.BREADY;
            if (rsp_valid != '0) rsp_n++;
            if (bus.WVALID && bus.WDATA !== 32'hA5A55A5A) wd_bad++;
            @(negedge ACLK);
        end
        chk("split_awvalid_cycles", awv_n, 1);
        chk("split_wvalid_cycles", wv_n, 4);
        chk("split_wdata_stable", wd_bad, 0);
        chk("split_bready_cycles", bready_n, 1);
        chk("split_rsp_count", rsp_n, 1);
        cfg_w_wait = 0;
        drain();

        // Slow B response with the other requester waiting.
        cfg_b_wait = 5;
        issue(0, 1'b1, 8'h18, 32'h0BADF00D, 4'hF);
        req_write[1] = 1'b0; req_addr[AW +: AW] = 8'h18; req_valid[1] = 1'b1;
        bready_n = 0; rr_bad = 0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            bready_n += bus.BREADY;
            if (req_ready != '0) rr_bad++;
            @(negedge ACLK);
        end
        #1;
        chk("slow_bready_cycles", bready_n, 6);
        chk("slow_req_ready_blocked", rr_bad, 0);
        chk("slow_rsp_cycle", rsp_valid, 2'b01);
        chk("slow_next_grant", req_ready, 2'b10);
        cfg_b_wait = 0;
        issue(1, 1'b0, 8'h18, 32'h0, 4'h0);
        drain();
        chk("slow_readback", rsp_rdata, 32'h0BADF00D);

        // Error responses passed through unchanged.
        cfg_rresp = 2'b10;
        issue(1, 1'b0, 8'h08, 32'h0, 4'h0);
        drain();
        chk("err_rresp", rsp_resp, 2'b10);
        cfg_rresp = 2'b00;
        cfg_bresp = 2'b11;
        issue(0, 1'b1, 8'h20, 32'h12345678, 4'hF);
        drain();
        chk("err_bresp", rsp_resp, 2'b11);
        cfg_bresp = 2'b00;

        // Reset while waiting in WR_RESP.
        cfg_b_wait = 5;
        issue(0, 1'b1, 8'h30, 32'hFFFFFFFF, 4'hF);
        @(negedge ACLK);
        chk("rst_mid_bready_before", bus.BREADY, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("rst_mid_axi_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY}, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        ARESET = 1'b0;
        cfg_b_wait = 0;
        grant_log.delete();
        fork
            issue(0, 1'b0, 8'h10, 32'h0, 4'h0);
            issue(1, 1'b0, 8'h14, 32'h0, 4'h0);
        join
        drain();
        chk("rst_mid_first_grant", grant_log.size() > 0 ? grant_log[0] : 99, 0);
        chk("rst_mid_second_grant", grant_log.size() > 1 ? grant_log[1] : 99, 1);

        repeat (4) @(negedge ACLK);
        chk("final_queue_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_rr_master_arbiter.md
Name: axi_lite_rr_master_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ internal requesters, each using a simple command/response interface.
- Arbitration is round-robin. Exactly one AXI transaction is outstanding at a time.
- Drives AW and W together for writes and AR for reads, then returns the B or R result to the granted requester as a one-cycle pulse.
- Sits in front of the register-file AXI4-Lite slave.

Parameters:
- ADDR_WIDTH, 8, AXI and requester address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- NUM_REQ, 2, number of requesters; must be 2 or more.

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accept; combinational, one-hot or zero
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot; no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid; holds last value otherwise
- rsp_resp  out  2  BRESP or RRESP of the completed transaction
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH
- WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8
- BVALID in 1, BREADY out 1, BRESP in 2
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH
- RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2

Behaviour:
- States:
  - IDLE
  - WR_ADDR: AW and W outstanding
  - WR_RESP
  - RD_ADDR
  - RD_DATA
- Reset (ARESET=1 at an edge, including mid-transaction):
  - state=IDLE, rr_ptr=0.
  - All AXI valid/ready outputs=0; AWADDR, ARADDR, WDATA, WSTRB=0.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, grant register=0.
  - The in-flight command is dropped with no response. The slave must be reset alongside.
- IDLE, grant selection: grant g = the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ. req_ready[g]=1 in the same cycle; req_ready is 0 outside IDLE.
- Accept edge:
  - Latch g, address, wdata and wstrb.
  - Write: go to WR_ADDR with AWVALID=WVALID=1. Read: go to RD_ADDR with ARVALID=1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- WR_ADDR:
  - AWVALID drops at the edge where AWREADY=1; WVALID drops independently at the edge where WREADY=1.
  - When both handshakes are done (same or different cycles), go to WR_RESP with BREADY=1.
  - Address and data stay stable while their valid is high.
- WR_RESP:
  - On an edge with BVALID=1: capture BRESP into rsp_resp, pulse rsp_valid[g] for the next cycle, BREADY<=0, go to IDLE.
- RD_ADDR:
  - On an edge with ARREADY=1: ARVALID<=0, RREADY<=1, go to RD_DATA.
- RD_DATA:
  - On an edge with RVALID=1: capture RDATA and RRESP, pulse rsp_valid[g] for the next cycle, RREADY<=0, go to IDLE.
- The rsp_valid cycle is spent in IDLE, so a new grant may coincide with it.
- Latency with a zero-wait slave (AWREADY=WREADY=ARREADY=1, registered B/R): accept at cycle 0, AXI address at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3. Back-to-back throughput is one transaction per 3 cycles.
- Requester rules:
  - A requester must hold req_valid and its command stable until req_ready.
  - Deasserting before grant is permitted; the request is simply not granted.
- BVALID or RVALID arriving outside WR_RESP / RD_DATA is ignored; BREADY and RREADY stay 0.
- rsp_resp is passed through unmodified, including SLVERR and DECERR.

Optional Feature:
- Macro AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_valid=1 always wins; rr_ptr is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Single write: req0 write addr=0x08, wdata=0xDEADBEEF, wstrb=0xF, zero-wait slave -> AW/W at cycle 1 with AWADDR=0x08; rsp_valid[0] at cycle 3; rsp_resp=0. A following read of 0x08 from req1 -> rsp_rdata=0xDEADBEEF.
- Round-robin: req0 and req1 both valid continuously with reads -> grants alternate 0,1,0,1. Under AXI_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
- Split W/AW: slave stalls WREADY 3 cycles after AWREADY -> WVALID held with stable data; AWVALID low after its handshake; single BREADY phase; exactly one rsp_valid.
- Slow response: BVALID delayed 5 cycles -> BREADY held high throughout; req_ready stays 0 for the second requester until completion.
- Error pass-through: slave returns RRESP=2'b10 with RDATA=0x0 -> rsp_resp=2'b10, rsp_valid on the granted requester only.
- Reset mid-transaction: ARESET asserted in WR_RESP -> next cycle all AXI valids/readies 0, no rsp_valid, state IDLE, next grant goes to requester 0.
